// File: rtl/fetch_controller.sv
// fetch_controller: owns the fetch PC, keeps one request in flight to instruction
// memory, hands fetched words to decode over valid/ready and steers the PC on
// branch/jump redirects.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect
// targets instead of silently clearing the low two address bits.
module fetch_controller #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misalign
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_KILL = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            idle_done_q, idle_done_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_data_q, inst_data_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            misalign_q, misalign_d;

  // redir_ok: a redirect that moves the PC; redir_bad: a redirect that traps.
  // Once trapped, further redirects are ignored until reset.
  logic            redir_ok;
  logic            redir_bad;
  logic [XLEN-1:0] redir_target;
  logic            req_fire;
  logic            handshake;
  logic [XLEN-1:0] step_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_bad    = redirect_valid & (|redirect_pc[1:0]) & ~misalign_q;
  assign redir_ok     = redirect_valid & ~(|redirect_pc[1:0]) & ~misalign_q;
  assign redir_target = redirect_pc;
`else
  assign redir_bad    = 1'b0;
  assign redir_ok     = redirect_valid & ~misalign_q;
  assign redir_target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif

  assign req_fire  = req_valid_q & imem_req_ready;
  assign handshake = inst_valid_q & inst_ready;
  assign step_pc   = pc_q + XLEN'(PC_STEP);

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    idle_done_d  = idle_done_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    misalign_d   = misalign_q;

    if (redir_bad) begin
      misalign_d = 1'b1;
    end
    if (redir_ok) begin
      pc_d = redir_target;
    end

    case (state_q)
      ST_IDLE: begin
        if (idle_done_q) begin
          state_d     = ST_REQ;
          req_valid_d = ~misalign_d;
          req_addr_d  = pc_d;
        end else begin
          idle_done_d = 1'b1;
        end
      end

      ST_REQ: begin
        if (req_fire) begin
          // A redirect racing the acceptance leaves a stale response in flight.
          req_valid_d = 1'b0;
          state_d     = (redir_ok | redir_bad) ? ST_KILL : ST_WAIT;
        end else if (redir_ok) begin
          req_addr_d = redir_target;
        end else if (redir_bad) begin
          req_valid_d = 1'b0;
        end
      end

      ST_WAIT: begin
        if (redir_ok | redir_bad) begin
          if (imem_rsp_valid) begin
            // Response already arrived this cycle: drop it, nothing left to drain.
            state_d     = ST_REQ;
            req_valid_d = ~misalign_d;
            req_addr_d  = pc_d;
          end else begin
            state_d = ST_KILL;
          end
        end else if (imem_rsp_valid) begin
          inst_valid_d = 1'b1;
          inst_data_d  = imem_rsp_data;
          inst_pc_d    = pc_q;
          state_d      = ST_HOLD;
        end
      end

      ST_KILL: begin
        if (imem_rsp_valid) begin
          state_d     = ST_REQ;
          req_valid_d = ~misalign_d;
          req_addr_d  = pc_d;
        end
      end

      ST_HOLD: begin
        if (redir_ok | redir_bad | handshake) begin
          // A handshake alongside a redirect still consumes the word, but the
          // redirect target wins over the sequential PC.
          if (!redir_ok && handshake) begin
            pc_d = step_pc;
          end
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
          req_valid_d  = ~misalign_d;
          req_addr_d   = pc_d;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight fetch immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      idle_done_q  <= 1'b0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'h0;
      inst_pc_q    <= {XLEN{1'b0}};
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      idle_done_q  <= idle_done_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed testbench for fetch_controller: one task per scenario, inline checks.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_inst_valid, w_inst_ready;
  logic [31:0] w_inst_data, w_inst_pc;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_fetch_misalign;

  int tests_run;
  int tests_failed;

  fetch_controller dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_misalign(fetch_misalign)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst_data(w_inst_data),
    .inst_pc(w_inst_pc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .fetch_misalign(w_fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
    w_inst_ready = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0;
    step();
    step();
    tests_run++;
    if ({req_valid, inst_valid, fetch_misalign} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, expected 000", {req_valid, inst_valid, fetch_misalign});
    end
    tests_run++;
    if (req_addr !== 32'h0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_values: got addr=%h data=%h pc=%h, expected all 0", req_addr, inst_data, inst_pc);
    end
    tests_run++;
    if (w_req_addr !== 32'hFFFF_FFFC || w_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pc_param: got addr=%h valid=%b, expected fffffffc/0", w_req_addr, w_req_valid);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_cycle: got req_valid=%b, expected 0", req_valid);
    end
    step();
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL first_req: got valid=%b addr=%h, expected 1/00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_sequential();
    req_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (req_valid !== 1'b1 || req_addr !== 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL seq_req%0d: got valid=%b addr=%h, expected 1/%h", i, req_valid, req_addr, 32'(4 * i));
      end
      step();
      tests_run++;
      if (req_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL seq_wait%0d: got req_valid=%b, expected 0", i, req_valid);
      end
      rsp_valid = 1'b1;
      rsp_data = 32'h1000_0000 + 32'(i);
      step();
      rsp_valid = 1'b0;
      tests_run++;
      if (inst_valid !== 1'b1 || inst_data !== 32'h1000_0000 + 32'(i) || inst_pc !== 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL seq_inst%0d: got v=%b data=%h pc=%h, expected 1/%h/%h", i, inst_valid,
                 inst_data, inst_pc, 32'h1000_0000 + 32'(i), 32'(4 * i));
      end
      $display("[TB] fetch pc=%h data=%h", inst_pc, inst_data);
      step();
    end
  endtask

  task automatic test_hold_stall();
    inst_ready = 1'b0;
    step();
    rsp_valid = 1'b1;
    rsp_data = 32'hCAFE_0001;
    step();
    rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (inst_valid !== 1'b1 || inst_data !== 32'hCAFE_0001 || inst_pc !== 32'hC || req_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_stable%0d: got v=%b data=%h pc=%h req=%b, expected 1/cafe0001/0000000c/0",
                 i, inst_valid, inst_data, inst_pc, req_valid);
      end
      step();
    end
    inst_ready = 1'b1;
    step();
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h10 || inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_release: got req=%b addr=%h iv=%b, expected 1/00000010/0", req_valid, req_addr, inst_valid);
    end
    $display("[TB] stalled word consumed, next addr=%h", req_addr);
  endtask

  task automatic test_redirect_wait();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL kill_state: got req=%b iv=%b, expected 0/0", req_valid, inst_valid);
    end
    rsp_valid = 1'b1;
    rsp_data = 32'hDEAD;
    step();
    rsp_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL kill_drop: got iv=%b req=%b addr=%h, expected 0/1/00000100", inst_valid, req_valid, req_addr);
    end
    $display("[TB] redirect in WAIT, stale word dropped, next addr=%h", req_addr);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    rsp_valid = 1'b1;
    rsp_data = 32'hBEEF;
    step();
    redirect_valid = 1'b0;
    rsp_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL wait_same_cycle: got iv=%b req=%b addr=%h, expected 0/1/00000200", inst_valid, req_valid, req_addr);
    end
  endtask

  task automatic test_redirect_req();
    req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h80) begin
      tests_failed++;
      $display("FAIL req_redirect: got valid=%b addr=%h, expected 1/00000080", req_valid, req_addr);
    end
    req_ready = 1'b1;
    step();
    rsp_valid = 1'b1;
    rsp_data = 32'h8080_8080;
    step();
    rsp_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst_data !== 32'h8080_8080) begin
      tests_failed++;
      $display("FAIL req_redirect_inst: got v=%b pc=%h data=%h, expected 1/00000080/80808080", inst_valid, inst_pc, inst_data);
    end
    step();
    tests_run++;
    if (req_addr !== 32'h84) begin
      tests_failed++;
      $display("FAIL req_redirect_next: got addr=%h, expected 00000084", req_addr);
    end
  endtask

  task automatic test_consume_redirect();
    int consumed;
    consumed = 0;
    step();
    rsp_valid = 1'b1;
    rsp_data = 32'h5555_0000;
    step();
    rsp_valid = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    if (inst_valid && inst_ready) consumed++;
    step();
    redirect_valid = 1'b0;
    if (inst_valid && inst_ready) consumed++;
    tests_run++;
    if (consumed !== 1) begin
      tests_failed++;
      $display("FAIL consume_once: got %0d handshakes, expected 1", consumed);
    end
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h40) begin
      tests_failed++;
      $display("FAIL consume_redirect: got valid=%b addr=%h, expected 1/00000040", req_valid, req_addr);
    end
    step();
    rsp_valid = 1'b1;
    rsp_data = 32'h6666_0000;
    step();
    rsp_valid = 1'b0;
    tests_run++;
    if (inst_pc !== 32'h40 || inst_data !== 32'h6666_0000) begin
      tests_failed++;
      $display("FAIL consume_target: got pc=%h data=%h, expected 00000040/66660000", inst_pc, inst_data);
    end
    $display("[TB] fetch pc=%h data=%h", inst_pc, inst_data);
    step();
    tests_run++;
    if (req_addr !== 32'h44) begin
      tests_failed++;
      $display("FAIL consume_next: got addr=%h, expected 00000044", req_addr);
    end
  endtask

  task automatic test_pc_wrap();
    req_ready = 1'b0;
    w_req_ready = 1'b1;
    step();
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data = 32'h77;
    step();
    w_rsp_valid = 1'b0;
    tests_run++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_inst: got v=%b pc=%h, expected 1/fffffffc", w_inst_valid, w_inst_pc);
    end
    w_inst_ready = 1'b1;
    step();
    tests_run++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_next: got valid=%b addr=%h, expected 1/00000000", w_req_valid, w_req_addr);
    end
    $display("[TB] wrap fetch pc=%h next addr=%h", w_inst_pc, w_req_addr);
  endtask

  task automatic test_misalign();
    req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    tests_run++;
    if (fetch_misalign !== 1'b1 || req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_trap: got flag=%b req=%b, expected 1/0", fetch_misalign, req_valid);
    end
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (fetch_misalign !== 1'b1 || req_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL misalign_hold%0d: got flag=%b req=%b, expected 1/0", i, fetch_misalign, req_valid);
      end
    end
`else
    tests_run++;
    if (fetch_misalign !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL misalign_mask: got flag=%b req=%b addr=%h, expected 0/1/00000100",
               fetch_misalign, req_valid, req_addr);
    end
    req_ready = 1'b1;
`endif
    $display("[TB] redirect 00000102 -> flag=%b addr=%h", fetch_misalign, req_addr);
  endtask

  task automatic test_async_reset();
    step();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0 || req_addr !== 32'h0 ||
        inst_pc !== 32'h0 || fetch_misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got req=%b iv=%b addr=%h pc=%h flag=%b, expected 0/0/0/0/0",
               req_valid, inst_valid, req_addr, inst_pc, fetch_misalign);
    end
    rsp_valid = 1'b1;
    rsp_data = 32'hBAD0_BAD0;
    step();
    rst = 1'b0;
    step();
    rsp_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_rsp: got iv=%b req=%b, expected 0/0", inst_valid, req_valid);
    end
    step();
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0 || inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart: got req=%b addr=%h iv=%b, expected 1/00000000/0", req_valid, req_addr, inst_valid);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_req();
    test_consume_redirect();
    test_pc_wrap();
    test_misalign();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
